reg_dump_reader: RTL and testbench

Read-side scan engine for the 32×32 register file's client read port. On a start command it walks `ClientRegAddr` over an inclusive address range (wrapping past 31 to 0) and captures each `ClientRegData` word. Each word is emitted, tagged with its address, on a valid/ready output stream. It sits between the register file and the debug/host link, giving the host a full or partial register dump without stalling the datapath's A/B read ports.

---
 rtl/reg_dump_pkg.sv | 14 +
 rtl/reg_dump_reader.sv | 121 ++++++++++++
 tb/tb_reg_dump_reader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file dump reader.
package reg_dump_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SEND  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file's client read port over an inclusive, wrapping
// address range and streams each word out on a valid/ready interface.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] ClientRegAddr,
  input  logic [DATA_W-1:0] ClientRegData,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              OutLast,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              olast_q, olast_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      olast_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      olast_q <= olast_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: latch range in IDLE, capture in SETUP, handshake in SEND.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    olast_d = olast_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          ptr_d   = FirstAddr;
          last_d  = LastAddr;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (Abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          data_d  = ClientRegData;
          oaddr_d = ptr_q;
          olast_d = (ptr_q == last_q);
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A handshake coinciding with Abort still delivers the word, but
        // Abort wins the transition and suppresses Done.
        if (Abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (valid_q && OutReady) begin
          valid_d = 1'b0;
          if (olast_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_SETUP;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ClientRegAddr = ptr_q;
  assign OutData       = data_q;
  assign OutAddr       = oaddr_q;
  assign OutLast       = olast_q;
  assign OutValid      = valid_q;
  assign Busy          = (state_q != ST_IDLE);
  assign Done          = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural 32x32 register file.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Abort;
  logic [4:0]  FirstAddr;
  logic [4:0]  LastAddr;
  logic [4:0]  ClientRegAddr;
  logic [31:0] ClientRegData;
  logic [31:0] OutData;
  logic [4:0]  OutAddr;
  logic        OutLast;
  logic        OutValid;
  logic        OutReady;
  logic        Busy;
  logic        Done;

  logic [31:0] regs [REG_COUNT];

  int n_chk;
  int n_fail;

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
    .FirstAddr(FirstAddr), .LastAddr(LastAddr),
    .ClientRegAddr(ClientRegAddr), .ClientRegData(ClientRegData),
    .OutData(OutData), .OutAddr(OutAddr), .OutLast(OutLast),
    .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  assign ClientRegData = regs[ClientRegAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue Start for one edge, then hold Start high with a decoy range so a
  // wrongly re-latched range would show up in the address checks.
  task automatic start_cmd(input logic [4:0] f, input logic [4:0] l);
    Start = 1'b1;
    FirstAddr = f;
    LastAddr = l;
    tick();
    chk("start_busy", {31'd0, Busy}, 32'd1);
    chk("start_valid", {31'd0, OutValid}, 32'd0);
    chk("start_cra", {27'd0, ClientRegAddr}, {27'd0, f});
    FirstAddr = ~f;
    LastAddr = ~l;
  endtask

  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int n,
                         input int stall_w, input int stall_n);
    logic [4:0] a;
    start_cmd(f, l);
    for (int i = 0; i < n; i++) begin
      a = f + 5'(i);
      tick();
      chk("word_valid", {31'd0, OutValid}, 32'd1);
      chk("word_addr", {27'd0, OutAddr}, {27'd0, a});
      chk("word_data", OutData, 32'h100 + {27'd0, a});
      chk("word_last", {31'd0, OutLast}, (i == n - 1) ? 32'd1 : 32'd0);
      if (i == stall_w) begin
        OutReady = 1'b0;
        for (int j = 0; j < stall_n; j++) begin
          tick();
          chk("stall_valid", {31'd0, OutValid}, 32'd1);
          chk("stall_addr", {27'd0, OutAddr}, {27'd0, a});
          chk("stall_data", OutData, 32'h100 + {27'd0, a});
        end
        OutReady = 1'b1;
      end
      tick();
      if (i == n - 1) begin
        chk("done_pulse", {31'd0, Done}, 32'd1);
        chk("done_busy", {31'd0, Busy}, 32'd0);
        chk("done_valid", {31'd0, OutValid}, 32'd0);
        Start = 1'b0;
      end else begin
        chk("gap_valid", {31'd0, OutValid}, 32'd0);
        chk("gap_done", {31'd0, Done}, 32'd0);
        chk("gap_busy", {31'd0, Busy}, 32'd1);
      end
    end
    tick();
    chk("done_once", {31'd0, Done}, 32'd0);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    Rst = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    FirstAddr = '0;
    LastAddr = '0;
    OutReady = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_data", OutData, 32'd0);
    chk("rst_addr", {27'd0, OutAddr}, 32'd0);
    chk("rst_cra", {27'd0, ClientRegAddr}, 32'd0);
    Rst = 1'b1;
    tick();

    // Full dump, wrapping dump, single word, backpressure on the second word.
    do_dump(5'd0, 5'd31, 32, -1, 0);
    do_dump(5'd30, 5'd1, 4, -1, 0);
    do_dump(5'd7, 5'd7, 1, -1, 0);
    do_dump(5'd0, 5'd3, 4, 1, 5);

    // Abort while the third word of a 0..9 dump is waiting.
    start_cmd(5'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abt_valid", {31'd0, OutValid}, 32'd1);
      chk("abt_addr", {27'd0, OutAddr}, i);
      if (i < 2) tick();
    end
    Abort = 1'b1;
    OutReady = 1'b0;
    Start = 1'b0;
    tick();
    chk("abt_valid_fall", {31'd0, OutValid}, 32'd0);
    chk("abt_busy", {31'd0, Busy}, 32'd0);
    chk("abt_done", {31'd0, Done}, 32'd0);
    Abort = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abt_no_done", {31'd0, Done}, 32'd0);
    end
    do_dump(5'd3, 5'd4, 2, -1, 0);

    // Asynchronous reset mid-dump.
    start_cmd(5'd0, 5'd9);
    tick();
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, OutValid}, 32'd1);
    Start = 1'b0;
    #3;
    Rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, OutValid}, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_data", OutData, 32'd0);
    chk("arst_addr", {27'd0, OutAddr}, 32'd0);
    chk("arst_last", {31'd0, OutLast}, 32'd0);
    chk("arst_cra", {27'd0, ClientRegAddr}, 32'd0);
    #2;
    Rst = 1'b1;
    tick();
    do_dump(5'd5, 5'd5, 1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
